// File: rtl/sdram_port_pkg.sv
// Shared definitions for the SDRAM command/data port: command codes, data width
// and the responder state encoding.
package sdram_port_pkg;

    localparam logic [1:0] CMD_IDLE     = 2'd0;
    localparam logic [1:0] CMD_WRITE    = 2'd1;
    localparam logic [1:0] CMD_READ     = 2'd2;
    localparam logic [1:0] CMD_RESERVED = 2'd3;

    localparam int DATA_WIDTH    = 16;
    localparam int ADDRESS_WIDTH = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_WAIT,
        ST_WR_DATA,
        ST_RECOVER,
        ST_REFRESH
    } state_t;

endpackage

// File: rtl/sdram_port_mem.sv
// Simple dual-port synchronous RAM with registered read and no reset, so it maps
// onto block RAM.
module sdram_port_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/sdram_port_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller port: serves burst reads and writes
// with SDRAM-like latency, per-word write handshakes and periodic refresh stalls.
module sdram_port_bram_responder
    import sdram_port_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int BURST_LENGTH   = 8,
    parameter int READ_LATENCY   = 3,
    parameter int WRITE_LATENCY  = 2,
    parameter int WRITE_GAP      = 2,
    parameter int REFRESH_PERIOD = 750,
    parameter int REFRESH_CYCLES = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               command,
    input  logic [ADDRESS_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0]    data_write,
    output logic [DATA_WIDTH-1:0]    data_read,
    output logic                     data_read_valid,
    output logic                     data_write_done,
    output logic                     busy,
    output logic                     protocol_error
);

    localparam int BEAT_W = $clog2(BURST_LENGTH) + 1;
    localparam int CNT_W  = 16;

    localparam logic [BEAT_W-1:0] BEAT_LAST    = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [CNT_W-1:0]  RD_WAIT_LAST = CNT_W'(READ_LATENCY - 2);
    localparam logic [CNT_W-1:0]  WR_WAIT_LAST = CNT_W'((WRITE_LATENCY >= 2) ? WRITE_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(WRITE_GAP - 1);
    localparam logic [CNT_W-1:0]  REF_LAST     = CNT_W'((REFRESH_CYCLES >= 1) ? REFRESH_CYCLES - 1 : 0);

    state_t                  state_reg, state_next;
    logic [1:0]              cmd_reg, cmd_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [BEAT_W-1:0]       beat_reg, beat_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    error_reg, error_next;
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic                    pending_reg;
    logic                    clear_pending;
    logic                    violation;
    logic                    valid;
    logic                    done;
    logic                    mem_wr_en;
    logic                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]   mem_wr_addr;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr;
    logic [DATA_WIDTH-1:0]   mem_rd_data;
    logic [ADDRESS_WIDTH-1:0] unused_address;

    // Upper address bits are deliberately dropped: the RAM only holds 2**ADDR_WIDTH words.
    assign unused_address = data_address;
    assign violation      = (command != cmd_reg);
    assign mem_wr_addr    = addr_reg + ADDR_WIDTH'(beat_reg);

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        addr_next     = addr_reg;
        beat_next     = beat_reg;
        cnt_next      = cnt_reg;
        error_next    = error_reg;
        clear_pending = 1'b0;
        valid         = 1'b0;
        done          = 1'b0;
        mem_wr_en     = 1'b0;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = addr_reg + ADDR_WIDTH'(beat_reg);

        case (state_reg)
            ST_IDLE: begin
                if (pending_reg) begin
                    state_next    = ST_REFRESH;
                    cnt_next      = '0;
                    clear_pending = 1'b1;
                end else if (command == CMD_WRITE || command == CMD_READ) begin
                    cmd_next   = command;
                    addr_next  = data_address[ADDR_WIDTH-1:0];
                    beat_next  = '0;
                    cnt_next   = '0;
                    if (command == CMD_READ) begin
                        state_next = ST_RD_WAIT;
                    end else begin
                        state_next = (WRITE_LATENCY == 1) ? ST_WR_DATA : ST_WR_WAIT;
                    end
                end else if (command == CMD_RESERVED) begin
                    error_next = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (violation) begin
                    error_next = 1'b1;
                    state_next = ST_RECOVER;
                end else if (cnt_reg == RD_WAIT_LAST) begin
                    // Prefetch word 0 so it sits in the RAM output register on entry to RD_DATA.
                    mem_rd_en  = 1'b1;
                    state_next = ST_RD_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RD_DATA: begin
                if (violation) begin
                    error_next = 1'b1;
                    state_next = ST_RECOVER;
                end else begin
                    valid = 1'b1;
                    if (beat_reg == BEAT_LAST) begin
                        state_next = ST_RECOVER;
                    end else begin
                        beat_next   = beat_reg + BEAT_W'(1);
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = addr_reg + ADDR_WIDTH'(beat_reg) + ADDR_WIDTH'(1);
                    end
                end
            end
            ST_WR_WAIT: begin
                if (violation) begin
                    error_next = 1'b1;
                    state_next = ST_RECOVER;
                end else if (cnt_reg == WR_WAIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_WR_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WR_DATA: begin
                if (violation) begin
                    error_next = 1'b1;
                    state_next = ST_RECOVER;
                end else begin
                    cnt_next = (cnt_reg == GAP_LAST) ? '0 : cnt_reg + CNT_W'(1);
                    if (cnt_reg == '0) begin
                        done      = 1'b1;
                        mem_wr_en = 1'b1;
                        if (beat_reg == BEAT_LAST) begin
                            state_next = ST_RECOVER;
                        end else begin
                            beat_next = beat_reg + BEAT_W'(1);
                        end
                    end
                end
            end
            ST_RECOVER: begin
                state_next = ST_IDLE;
            end
            ST_REFRESH: begin
                if (cnt_reg == REF_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cmd_reg   <= CMD_IDLE;
            addr_reg  <= '0;
            beat_reg  <= '0;
            cnt_reg   <= '0;
            error_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            addr_reg  <= addr_next;
            beat_reg  <= beat_next;
            cnt_reg   <= cnt_next;
            error_reg <= error_next;
            if (valid) begin
                hold_reg <= mem_rd_data;
            end
        end
    end

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            localparam int TIMER_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_PERIOD - 1);
            logic [TIMER_W-1:0] timer_reg;

            // A wrap takes priority over the clear so a wrap on REFRESH entry is not lost.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    timer_reg   <= '0;
                    pending_reg <= 1'b0;
                end else if (timer_reg == TIMER_LAST) begin
                    timer_reg   <= '0;
                    pending_reg <= 1'b1;
                end else begin
                    timer_reg <= timer_reg + TIMER_W'(1);
                    if (clear_pending) begin
                        pending_reg <= 1'b0;
                    end
                end
            end
        end else begin : g_no_refresh
            logic unused_clear;
            assign unused_clear = clear_pending;
            assign pending_reg  = 1'b0;
        end
    endgenerate

    sdram_port_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_wr_en),
        .wr_addr(mem_wr_addr),
        .wr_data(data_write),
        .rd_en  (mem_rd_en),
        .rd_addr(mem_rd_addr),
        .rd_data(mem_rd_data)
    );

    assign data_read       = valid ? mem_rd_data : hold_reg;
    assign data_read_valid = valid;
    assign data_write_done = done;
    assign busy            = (state_reg != ST_IDLE);
    assign protocol_error  = error_reg;

endmodule

// File: tb/tb_sdram_port_bram_responder.sv
// Self-checking bench: randomized bursts against an array model of the RAM, with
// pulse timing derived from the latency/gap/refresh parameters.
module tb_sdram_port_bram_responder;
    import sdram_port_pkg::*;

    localparam int BL = 8, RL = 3, WL = 2, GAP = 2, RP = 20, RC = 7, DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  command, command_rf;
    logic [21:0] data_address, addr_rf;
    logic [15:0] data_write, write_rf;
    logic [15:0] data_read, data_read_rf;
    logic        data_read_valid, data_write_done, busy, protocol_error;
    logic        valid_rf, done_rf, busy_rf, error_rf;

    always #5 clk = ~clk;

    sdram_port_bram_responder #(.REFRESH_PERIOD(0)) dut (
        .clk(clk), .reset(rst), .command(command), .data_address(data_address),
        .data_write(data_write), .data_read(data_read), .data_read_valid(data_read_valid),
        .data_write_done(data_write_done), .busy(busy), .protocol_error(protocol_error)
    );

    sdram_port_bram_responder #(.REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)) dut_rf (
        .clk(clk), .reset(rst), .command(command_rf), .data_address(addr_rf),
        .data_write(write_rf), .data_read(data_read_rf), .data_read_valid(valid_rf),
        .data_write_done(done_rf), .busy(busy_rf), .protocol_error(error_rf)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_mem [0:DEPTH-1];
    bit          known [0:DEPTH-1];
    logic [15:0] wdata [0:BL-1];
    int          pulse_k[$];
    logic [15:0] pulse_word[$];
    bit          busy_trace [0:63];

    task automatic do_reset();
        rst = 1'b1;
        command = CMD_IDLE; data_address = '0; data_write = '0;
        command_rf = CMD_IDLE; addr_rf = '0; write_rf = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one write burst, dropping the command after 'limit' dones; model records the spec outcome.
    task automatic write_burst(input logic [21:0] a, input int limit);
        int n;
        int base;
        n = 0;
        base = int'(a[9:0]);
        for (int i = 0; i < limit; i++) begin
            model_mem[(base + i) % DEPTH] = wdata[i];
            known[(base + i) % DEPTH] = 1'b1;
        end
        pulse_k.delete();
        @(posedge clk); #1;
        command = CMD_WRITE; data_address = a; data_write = wdata[0];
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (n >= limit) command = CMD_IDLE;
            else data_write = wdata[n];
            @(negedge clk);
            busy_trace[k] = busy;
            if (data_write_done) begin
                pulse_k.push_back(k);
                n++;
            end
        end
        command = CMD_IDLE;
    endtask

    // Drives one read burst; 'extra' keeps the command asserted that many cycles past the last beat.
    task automatic read_burst(input logic [21:0] a, input int extra);
        int n;
        int last;
        n = 0;
        last = -100;
        pulse_k.delete();
        pulse_word.delete();
        @(posedge clk); #1;
        command = CMD_READ; data_address = a;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (n >= BL && k > last + extra) command = CMD_IDLE;
            @(negedge clk);
            busy_trace[k] = busy;
            if (data_read_valid) begin
                pulse_k.push_back(k);
                pulse_word.push_back(data_read);
                n++;
                last = k;
            end
        end
        command = CMD_IDLE;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({data_read, data_read_valid, data_write_done, busy, protocol_error} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {data_read, data_read_valid, data_write_done, busy, protocol_error});
        end
        do_reset();
        checks++;
        if ({data_read_rf, valid_rf, done_rf, busy_rf, error_rf} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs_rf: got %h expected 0", {data_read_rf, valid_rf, done_rf, busy_rf, error_rf});
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < BL; i++) wdata[i] = 16'hA000 + 16'(i);
        write_burst(22'h10, BL);
        checks++;
        if (pulse_k.size() != BL) begin
            errors++;
            $display("FAIL wr_done_count: got %0d expected %0d", pulse_k.size(), BL);
        end
        for (int i = 0; i < BL && i < pulse_k.size(); i++) begin
            checks++;
            if (pulse_k[i] != WL + GAP * i) begin
                errors++;
                $display("FAIL wr_done_cycle[%0d]: got %0d expected %0d", i, pulse_k[i], WL + GAP * i);
            end
        end
        read_burst(22'h10, 0);
        checks++;
        if (pulse_k.size() != BL) begin
            errors++;
            $display("FAIL rd_valid_count: got %0d expected %0d", pulse_k.size(), BL);
        end
        for (int i = 0; i < BL && i < pulse_k.size(); i++) begin
            checks++;
            if (pulse_k[i] != RL + i || pulse_word[i] !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL rd_beat[%0d]: got cycle %0d data %h expected cycle %0d data %h",
                         i, pulse_k[i], pulse_word[i], RL + i, 16'hA000 + 16'(i));
            end
        end
        checks++;
        if (busy_trace[RL + BL] !== 1'b1 || busy_trace[RL + BL + 1] !== 1'b0) begin
            errors++;
            $display("FAIL busy_recover: got %b%b expected 10", busy_trace[RL + BL], busy_trace[RL + BL + 1]);
        end
    endtask

    // Reads a burst and compares every word whose address the model knows.
    task automatic check_read(input logic [21:0] a, input string tag);
        int base;
        int idx;
        base = int'(a[9:0]);
        read_burst(a, 0);
        checks++;
        if (pulse_word.size() != BL) begin
            errors++;
            $display("FAIL %s_count: got %0d expected %0d", tag, pulse_word.size(), BL);
        end
        for (int i = 0; i < BL && i < pulse_word.size(); i++) begin
            idx = (base + i) % DEPTH;
            if (known[idx]) begin
                checks++;
                if (pulse_word[i] !== model_mem[idx]) begin
                    errors++;
                    $display("FAIL %s_word[%0d] addr %0d: got %h expected %h", tag, i, idx, pulse_word[i], model_mem[idx]);
                end
            end
        end
    endtask

    task automatic test_random_bursts();
        logic [21:0] a;
        for (int t = 0; t < 5; t++) begin
            a = 22'($urandom);
            for (int i = 0; i < BL; i++) wdata[i] = 16'($urandom);
            write_burst(a, BL);
            check_read(a, "rand_same");
            check_read(a + 22'd3, "rand_overlap");
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < BL; i++) wdata[i] = 16'($urandom);
        write_burst(22'd1022, BL);
        check_read(22'd0, "wrap_low");
        check_read(22'd1022, "wrap_high");
    endtask

    task automatic test_hold_recover();
        read_burst(22'h10, 1);
        checks++;
        if (pulse_k.size() != BL) begin
            errors++;
            $display("FAIL hold_valid_count: got %0d expected %0d", pulse_k.size(), BL);
        end
        checks++;
        if (busy_trace[RL + BL + 1] !== 1'b0 || protocol_error !== 1'b0) begin
            errors++;
            $display("FAIL hold_recover: got busy %b err %b expected busy 0 err 0", busy_trace[RL + BL + 1], protocol_error);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < BL; i++) wdata[i] = 16'($urandom);
        write_burst(22'h200, BL);
        for (int i = 0; i < BL; i++) wdata[i] = 16'($urandom);
        write_burst(22'h200, 3);
        checks++;
        if (pulse_k.size() != 3) begin
            errors++;
            $display("FAIL abort_done_count: got %0d expected 3", pulse_k.size());
        end
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL abort_error: got %b expected 1", protocol_error);
        end
        check_read(22'h200, "abort_ram");
    endtask

    task automatic test_reserved();
        do_reset();
        @(posedge clk); #1;
        command = CMD_RESERVED;
        @(posedge clk); #1;
        command = CMD_IDLE;
        @(negedge clk);
        checks++;
        if (protocol_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reserved: got err %b busy %b expected err 1 busy 0", protocol_error, busy);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (protocol_error !== 1'b1) begin
            errors++;
            $display("FAIL error_sticky: got %b expected 1", protocol_error);
        end
    endtask

    // Timer wraps on the RP-th edge after release; read issued then waits out the refresh.
    task automatic test_refresh();
        int first_valid;
        int nvalid;
        bit b20, b21, b28;
        first_valid = -1;
        nvalid = 0;
        b20 = 1'b1; b21 = 1'b0; b28 = 1'b1;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk); #1;
            if (e == RP) begin
                command_rf = CMD_READ;
                addr_rf = 22'($urandom);
            end
            if (nvalid >= BL) command_rf = CMD_IDLE;
            @(negedge clk);
            if (e == RP) b20 = busy_rf;
            if (e == RP + 1) b21 = busy_rf;
            if (e == RP + RC + 1) b28 = busy_rf;
            if (valid_rf) begin
                if (first_valid < 0) first_valid = e;
                nvalid++;
            end
        end
        command_rf = CMD_IDLE;
        checks++;
        if (first_valid != RP + RC + 2 + RL - 1) begin
            errors++;
            $display("FAIL refresh_first_valid: got edge %0d expected %0d", first_valid, RP + RC + 2 + RL - 1);
        end
        checks++;
        if (nvalid != BL) begin
            errors++;
            $display("FAIL refresh_valid_count: got %0d expected %0d", nvalid, BL);
        end
        checks++;
        if ({b20, b21, b28} !== 3'b010) begin
            errors++;
            $display("FAIL refresh_busy: got %b%b%b expected 010", b20, b21, b28);
        end
    endtask

    task automatic test_reset_mid_read();
        int nv;
        nv = 0;
        do_reset();
        @(posedge clk); #1;
        command = CMD_READ; data_address = 22'h10;
        for (int k = 0; k < 20 && nv < 2; k++) begin
            @(negedge clk);
            if (data_read_valid) nv++;
        end
        checks++;
        if (nv != 2) begin
            errors++;
            $display("FAIL midread_start: got %0d valids expected 2", nv);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({data_read, data_read_valid, data_write_done, busy, protocol_error} !== 20'h0) begin
            errors++;
            $display("FAIL midread_reset: got %h expected 0", {data_read, data_read_valid, data_write_done, busy, protocol_error});
        end
        command = CMD_IDLE;
        @(negedge clk);
        rst = 1'b0;
        check_read(22'h10, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_random_bursts();
        test_wrap();
        test_hold_recover();
        test_abort();
        test_reserved();
        test_refresh();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
